// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: load-use, long-op scoreboard RAW/WAW and structural stalls, plus branch flush.
// Optional stall/flush cycle counters are enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_scoreboard #(
    parameter int MAX_PENDING = 2,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] if_id_rs1,
    input  logic [4:0] if_id_rs2,
    input  logic       if_id_uses_rs1,
    input  logic       if_id_uses_rs2,
    input  logic [4:0] if_id_rd,
    input  logic       if_id_reg_write,
    input  logic       if_id_long_op,
    input  logic       id_ex_mem_read,
    input  logic [4:0] id_ex_reg_rd,
    input  logic       lu_done,
    input  logic [4:0] lu_done_rd,
    input  logic       ex_branch_taken,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       id_ex_bubble,
    output logic       if_id_flush,
    output logic [1:0] stall_cause
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_LOAD_USE   = 2'b01,
        CAUSE_SCOREBOARD = 2'b10,
        CAUSE_FULL       = 2'b11
    } cause_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

    logic [31:1]      pending_q;
    logic [31:0]      pending;
    logic [CNT_W-1:0] count;

    logic   load_use, sb_raw, sb_waw, full, stall;
    logic   issue, complete;
    logic [31:0] set_mask, clr_mask;
    cause_e cause;

    // x0 is never tracked, so it can never raise a scoreboard hazard.
    assign pending = {pending_q, 1'b0};

    assign load_use = id_ex_mem_read && (id_ex_reg_rd != 5'd0) &&
                      ((if_id_uses_rs1 && (if_id_rs1 == id_ex_reg_rd)) ||
                       (if_id_uses_rs2 && (if_id_rs2 == id_ex_reg_rd)));
    assign sb_raw   = (if_id_uses_rs1 && pending[if_id_rs1]) ||
                      (if_id_uses_rs2 && pending[if_id_rs2]);
    assign sb_waw   = if_id_reg_write && (if_id_rd != 5'd0) && pending[if_id_rd];
    assign full     = if_id_long_op && if_id_reg_write && (count == MAX_CNT) && !lu_done;
    assign stall    = load_use || sb_raw || sb_waw || full;

    assign issue    = if_id_long_op && if_id_reg_write && (if_id_rd != 5'd0) &&
                      !stall && !ex_branch_taken && !reset;
    assign complete = lu_done && (lu_done_rd != 5'd0) && pending[lu_done_rd];

    assign set_mask = issue    ? (32'd1 << if_id_rd)   : 32'd0;
    assign clr_mask = complete ? (32'd1 << lu_done_rd) : 32'd0;

    // NOTE: every output gets a default before any branch so no path leaves one unassigned (no latch).
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        cause        = CAUSE_NONE;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (load_use)             cause = CAUSE_LOAD_USE;
            else if (sb_raw || sb_waw) cause = CAUSE_SCOREBOARD;
            else                       cause = CAUSE_FULL;
        end
    end

    assign stall_cause = cause;

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            count     <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_mask[31:1]) | set_mask[31:1];
            case ({issue, complete})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall && !ex_branch_taken && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (ex_branch_taken && (flush_cycles != 32'hFFFF_FFFF))
                flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= MAX_CNT);
            assert (!(issue && !complete && (count == MAX_CNT)));
            assert (!(complete && !issue && (count == '0)));
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: table-driven vectors plus multi-cycle scoreboard sequences.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] if_id_rs1, if_id_rs2, if_id_rd, id_ex_reg_rd, lu_done_rd;
    logic       if_id_uses_rs1, if_id_uses_rs2, if_id_reg_write, if_id_long_op;
    logic       id_ex_mem_read, lu_done, ex_branch_taken;
    logic       pc_write, if_id_write, id_ex_bubble, if_id_flush;
    logic [1:0] stall_cause;
`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard #(.MAX_PENDING(2), .CNT_W(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .if_id_rs1       (if_id_rs1),
        .if_id_rs2       (if_id_rs2),
        .if_id_uses_rs1  (if_id_uses_rs1),
        .if_id_uses_rs2  (if_id_uses_rs2),
        .if_id_rd        (if_id_rd),
        .if_id_reg_write (if_id_reg_write),
        .if_id_long_op   (if_id_long_op),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_reg_rd    (id_ex_reg_rd),
        .lu_done         (lu_done),
        .lu_done_rd      (lu_done_rd),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .stall_cause     (stall_cause)
`ifdef HAZARD_STALL_COUNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
`endif
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       lo;
        logic       mr;
        logic [4:0] exrd;
        logic       lud;
        logic [4:0] ludrd;
        logic       br;
    } vec_in_t;

    typedef struct {
        string      name;
        vec_in_t    in;
        logic [5:0] exp;
    } vec_t;

    // Output word: {pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_cause}
    localparam logic [5:0] NORMAL = 6'b11_0_0_00;
    localparam logic [5:0] FLUSH  = 6'b11_1_1_00;
    localparam logic [5:0] RST    = 6'b00_1_0_00;
    localparam logic [5:0] ST_LU  = 6'b00_1_0_01;
    localparam logic [5:0] ST_SB  = 6'b00_1_0_10;
    localparam logic [5:0] ST_FUL = 6'b00_1_0_11;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];
    vec_t       tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_in_t idle();
        vec_in_t v;
        v = '0;
        return v;
    endfunction

    function automatic vec_in_t long_op(input logic [4:0] rd);
        vec_in_t v;
        v = '0;
        v.rd = rd; v.rw = 1'b1; v.lo = 1'b1;
        return v;
    endfunction

    task automatic drive(input vec_in_t v);
        reset           = v.rst;
        if_id_rs1       = v.rs1;
        if_id_rs2       = v.rs2;
        if_id_uses_rs1  = v.u1;
        if_id_uses_rs2  = v.u2;
        if_id_rd        = v.rd;
        if_id_reg_write = v.rw;
        if_id_long_op   = v.lo;
        id_ex_mem_read  = v.mr;
        id_ex_reg_rd    = v.exrd;
        lu_done         = v.lud;
        lu_done_rd      = v.ludrd;
        ex_branch_taken = v.br;
    endtask

    // Drive one cycle of stimulus, compare the outputs mid-cycle, then advance past the edge.
    task automatic step(input string name, input vec_in_t v, input logic [5:0] exp);
        logic [5:0] e;
        drive(v);
        exp_q.push_back(exp);
        @(negedge clk);
        e = exp_q.pop_front();
        check(name, {26'd0, pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_cause}, {26'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input int exp_count, input logic [31:0] exp_pend);
        check({name, "_count"}, 32'(dut.count), exp_count);
        check({name, "_pending"}, dut.pending, exp_pend);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_in_t v;
        vec_t    r;

        drive(idle());
        reset = 1'b1;
        @(posedge clk);
        #1;

        v = idle(); v.rst = 1'b1;
        step("reset_outputs", v, RST);
        check_state("after_reset", 0, 32'd0);

        // Combinational vectors applied to an empty scoreboard; none of them issues a long op.
        r.name = "idle";            r.in = idle(); r.exp = NORMAL; tbl.push_back(r);
        r.name = "lu_rs1";          r.in = idle(); r.in.mr = 1; r.in.exrd = 5; r.in.rs1 = 5; r.in.u1 = 1; r.exp = ST_LU; tbl.push_back(r);
        r.name = "lu_rs2";          r.in = idle(); r.in.mr = 1; r.in.exrd = 5; r.in.rs2 = 5; r.in.u2 = 1; r.exp = ST_LU; tbl.push_back(r);
        r.name = "lu_rs1_unused";   r.in = idle(); r.in.mr = 1; r.in.exrd = 5; r.in.rs1 = 5; r.exp = NORMAL; tbl.push_back(r);
        r.name = "lu_x0";           r.in = idle(); r.in.mr = 1; r.in.exrd = 0; r.in.rs1 = 0; r.in.u1 = 1; r.exp = NORMAL; tbl.push_back(r);
        r.name = "no_load";         r.in = idle(); r.in.exrd = 5; r.in.rs1 = 5; r.in.u1 = 1; r.exp = NORMAL; tbl.push_back(r);
        r.name = "lu_rs_differs";   r.in = idle(); r.in.mr = 1; r.in.exrd = 5; r.in.rs1 = 6; r.in.u1 = 1; r.exp = NORMAL; tbl.push_back(r);
        r.name = "flush_over_lu";   r.in = idle(); r.in.mr = 1; r.in.exrd = 5; r.in.rs1 = 5; r.in.u1 = 1; r.in.br = 1; r.exp = FLUSH; tbl.push_back(r);
        r.name = "flush_long_op";   r.in = long_op(8); r.in.br = 1; r.exp = FLUSH; tbl.push_back(r);
        r.name = "long_op_x0";      r.in = long_op(0); r.exp = NORMAL; tbl.push_back(r);
        r.name = "done_not_pend";   r.in = idle(); r.in.lud = 1; r.in.ludrd = 12; r.exp = NORMAL; tbl.push_back(r);
        r.name = "reset_with_lu";   r.in = idle(); r.in.rst = 1; r.in.mr = 1; r.in.exrd = 5; r.in.rs1 = 5; r.in.u1 = 1; r.exp = RST; tbl.push_back(r);

        foreach (tbl[i]) step(tbl[i].name, tbl[i].in, tbl[i].exp);
        check_state("after_table", 0, 32'd0);

        // Scoreboard RAW: stall holds through the lu_done cycle and releases on the next.
        step("raw_issue7", long_op(7), NORMAL);
        check_state("raw_pending7", 1, 32'h80);
        v = idle(); v.rs2 = 7; v.u2 = 1;
        step("raw_stall", v, ST_SB);
        v.lud = 1; v.ludrd = 7;
        step("raw_stall_done_cycle", v, ST_SB);
        v.lud = 0; v.ludrd = 0;
        step("raw_release", v, NORMAL);
        check_state("raw_cleared", 0, 32'd0);

        // Structural full, released by a same-cycle completion.
        step("full_issue3", long_op(3), NORMAL);
        step("full_issue4", long_op(4), NORMAL);
        check_state("full_two", 2, 32'h18);
        step("full_stall", long_op(6), ST_FUL);
        check_state("full_stall_hold", 2, 32'h18);
        v = long_op(6); v.lud = 1; v.ludrd = 3;
        step("full_release", v, NORMAL);
        check_state("full_swap", 2, 32'h50);
        v = idle(); v.lud = 1; v.ludrd = 4;
        step("drain4", v, NORMAL);
        v.ludrd = 6;
        step("drain6", v, NORMAL);
        check_state("drained", 0, 32'd0);

        // WAW on a pending destination.
        step("waw_issue9", long_op(9), NORMAL);
        v = idle(); v.rd = 9; v.rw = 1;
        step("waw_stall", v, ST_SB);
        v.lud = 1; v.ludrd = 9;
        step("waw_stall_done_cycle", v, ST_SB);
        v.lud = 0; v.ludrd = 0;
        step("waw_release", v, NORMAL);
        check_state("waw_cleared", 0, 32'd0);

        // Reset in the middle of outstanding long ops.
        step("mid_issue3", long_op(3), NORMAL);
        step("mid_issue4", long_op(4), NORMAL);
        check_state("mid_pending", 2, 32'h18);
        v = long_op(5); v.rst = 1;
        step("mid_reset", v, RST);
        check_state("mid_after_reset", 0, 32'd0);
`ifdef HAZARD_STALL_COUNT_EN
        check("stall_cycles_reset", stall_cycles, 32'd0);
        check("flush_cycles_reset", flush_cycles, 32'd0);
        v = idle(); v.mr = 1; v.exrd = 5; v.rs1 = 5; v.u1 = 1;
        step("cnt_stall", v, ST_LU);
        v.br = 1;
        step("cnt_flush", v, FLUSH);
        check("stall_cycles_one", stall_cycles, 32'd1);
        check("flush_cycles_one", flush_cycles, 32'd1);
`endif

        step("final_idle", idle(), NORMAL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
